// File: rtl/dfp_arbiter_pkg.sv
// Shared types and sizing for the dfp cacheline arbiter.
// Imported by dfp_arbiter and dfp_arb_perf_counter.
package dfp_arb_types;

    localparam int NUM_REQ    = 2;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dfp_arbiter_perf_counter.sv
// Saturating event counter used by the arbiter perf ports.
// Instantiated only when DFP_ARB_PERF_EN is defined.
module dfp_arb_perf_counter
    import dfp_arb_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] count
);

    localparam logic [PERF_CNT_W-1:0] ONE = 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/dfp_arbiter.sv
// Round-robin arbiter: I-cache (0) and D-cache (1) share one line port.
// Define DFP_ARB_PERF_EN to build the grant/wait perf counters.
module dfp_arbiter
    import dfp_arb_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] req_addr    [NUM_REQ],
    input  logic                  req_read    [NUM_REQ],
    input  logic                  req_write   [NUM_REQ],
    input  logic [LINE_WIDTH-1:0] req_wdata   [NUM_REQ],
    output logic [LINE_WIDTH-1:0] req_rdata   [NUM_REQ],
    output logic                  req_resp    [NUM_REQ],
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [PERF_CNT_W-1:0] perf_grants [NUM_REQ],
    output logic [PERF_CNT_W-1:0] perf_wait   [NUM_REQ]
);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic               last_grant;
    logic               last_grant_nx;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] gnt_nx_oh;
    logic               gnt_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_act
        assign active[g] = req_read[g] | req_write[g];
    end

    assign gnt_oh    = {state == GRANT1, state == GRANT0};
    assign gnt_nx_oh = {state_nx == GRANT1, state_nx == GRANT0};
    assign gnt_idx   = gnt_oh[1];

    // The granted requester's own line is ignored on its mem_resp
    // cycle: it is still high for the transaction just completed.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        unique case (state)
            IDLE: begin
                if (active[0] && active[1]) begin
                    state_nx = last_grant ? GRANT0 : GRANT1;
                end else if (active[0]) begin
                    state_nx = GRANT0;
                end else if (active[1]) begin
                    state_nx = GRANT1;
                end
            end
            GRANT0: begin
                if (mem_resp) begin
                    state_nx = active[1] ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (mem_resp) begin
                    state_nx = active[0] ? GRANT0 : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (gnt_nx_oh[0] && !gnt_oh[0]) begin
            last_grant_nx = 1'b0;
        end else if (gnt_nx_oh[1] && !gnt_oh[1]) begin
            last_grant_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
        end
    end

    // Memory side depends only on registered state, never on mem_resp.
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        if (|gnt_oh) begin
            mem_addr  = req_addr[gnt_idx];
            mem_write = req_write[gnt_idx];
            mem_read  = req_read[gnt_idx] & ~req_write[gnt_idx];
            mem_wdata = req_wdata[gnt_idx];
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign req_resp[g]  = gnt_oh[g] & mem_resp;
        assign req_rdata[g] = gnt_oh[g] ? mem_rdata : '0;
    end

`ifdef DFP_ARB_PERF_EN
    logic [NUM_REQ-1:0] enter;
    logic [NUM_REQ-1:0] waiting;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign enter[g]   = gnt_nx_oh[g] & ~gnt_oh[g];
        assign waiting[g] = active[g] & ~gnt_oh[g] & ~gnt_nx_oh[g];

        dfp_arb_perf_counter u_grants (
            .clk   (clk),
            .rst   (rst),
            .inc   (enter[g]),
            .count (perf_grants[g])
        );

        dfp_arb_perf_counter u_wait (
            .clk   (clk),
            .rst   (rst),
            .inc   (waiting[g]),
            .count (perf_wait[g])
        );
    end
`else
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_grants[g] = '0;
        assign perf_wait[g]   = '0;
    end
`endif

endmodule

// File: doc/dfp_arbiter.md
# dfp_arbiter

Two-requester arbiter sharing a single 256-bit cacheline memory port between the instruction-side and data-side mutative caches. It sits between the caches' downward-facing ports and main memory. It grants one whole transaction (read line or write-back line) at a time, round-robin, and routes data and responses to the granted cache. Requesters hold `read`/`write` high until they see `resp`, matching the cache dfp protocol.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `LINE_WIDTH`, 256, cacheline width in bits.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_addr[2]`  in  ADDR_WIDTH  line-aligned address per requester (0 = I-cache, 1 = D-cache).
- `req_read[2]`  in  1  read-line request, held until `req_resp`.
- `req_write[2]`  in  1  write-line request, held until `req_resp`.
- `req_wdata[2]`  in  LINE_WIDTH  write data.
- `req_rdata[2]`  out  LINE_WIDTH  read data, valid with `req_resp`.
- `req_resp[2]`  out  1  transaction complete, one cycle.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_read`  out  1  memory read.
- `mem_write`  out  1  memory write.
- `mem_wdata`  out  LINE_WIDTH  memory write data.
- `mem_rdata`  in  LINE_WIDTH  memory read data.
- `mem_resp`  in  1  memory completion, one cycle.
- `perf_grants[2]`  out  32  granted transactions per requester (see Configuration).
- `perf_wait[2]`  out  32  cycles spent requesting without a grant (see Configuration).

## Operation
- A requester is active when `req_read | req_write` is high. If both are high, it is treated as a write; a bench assertion flags this case.
- FSM states are IDLE, GRANT0 and GRANT1.
- IDLE:
  - Neither requester active: stay in IDLE.
  - One active: go to its GRANT state.
  - Both active: grant the requester not equal to `last_grant`, then set `last_grant` to the granted index.
- GRANTn:
  - `mem_addr`, `mem_read`, `mem_write` and `mem_wdata` are driven combinationally from requester n.
  - `req_rdata[n]` equals `mem_rdata`. `req_resp[n]` equals `mem_resp`.
  - The other requester sees `req_resp = 0` and `req_rdata = 0`.
- On `mem_resp` in GRANTn:
  - Other requester active: go directly to GRANT(1-n) and update `last_grant`.
  - Otherwise: go to IDLE.
  - Requester n's own request is ignored on the `mem_resp` cycle, because its request line is still high for the completed transaction.
- Outside GRANT states, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are 0.
- A requester that drops its request mid-grant is a protocol violation. The arbiter stays in GRANT until `mem_resp`.
- A write-back followed by a refill from the same cache is two transactions. If the other cache is waiting, it may be granted between them.

## Timing
- Reset values:
  - State IDLE, `last_grant` = 1, so requester 0 wins the first tie.
  - All outputs 0. Perf counters 0.
- Arbitration latency is one cycle: a request first seen in IDLE at cycle t drives `mem_read`/`mem_write` at cycle t+1.
- Handoff on `mem_resp` has zero idle cycles: the other requester is on `mem_*` in the cycle after `mem_resp`.
- Requester-side latency equals memory latency plus 1 from IDLE, or plus 0 on a direct handoff.
- Asynchronous reset mid-transaction: the FSM returns to IDLE immediately and outputs are forced to 0. The in-flight memory transaction is abandoned, and memory must be reset together with the arbiter.
- No combinational path from `mem_resp` to `mem_read`/`mem_write`. Grant changes take effect the next cycle.

## Configuration
- Macro `DFP_ARB_PERF_EN`.
- Defined:
  - `perf_grants[n]` increments when GRANTn is entered.
  - `perf_wait[n]` increments every cycle requester n is active but the FSM is neither in GRANTn nor entering it.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the perf ports remain but are tied to 0, and no counter flops are synthesized.

## Structure
- Package `dfp_arb_types`:
  - `arb_state_t` enum (IDLE, GRANT0, GRANT1).
  - `NUM_REQ = 2`.
  - `PERF_CNT_W = 32`.
- Sub-module `dfp_arb_perf_counter`: one saturating counter with `inc` and asynchronous `rst`, instantiated four times under the macro.

## Test plan
- Lone read from requester 0 at 0x0000_1000, memory latency 3:
  - `mem_read` is high from cycle 1.
  - `req_resp[0]` is high in the cycle after the 3-cycle latency.
  - `req_rdata[0]` equals `mem_rdata`.
  - `req_resp[1]` stays 0 throughout.
- Both requesters read in the same cycle after reset:
  - Requester 0 is granted first.
  - Requester 1's address appears on `mem_addr` the cycle after requester 0's `mem_resp`.
- Both requesters request continuously for 8 transactions: grants alternate 0,1,0,1,… and each `perf_grants` reads 4 under `DFP_ARB_PERF_EN`.
- Requester 1 write-back to 0x0000_2000 with data `{8{32'hDEADBEEF}}`:
  - `mem_write` is 1 and `mem_wdata` matches the data.
  - `mem_read` stays 0.
  - `req_resp[1]` lasts exactly one cycle.
- Assert `rst` mid-grant, two cycles into a read: all outputs go to 0 in that cycle, and after release a new request is granted with one-cycle latency.
- Requester 0 waits 5 cycles behind requester 1's transaction: `perf_wait[0]` = 5 with the macro defined, 0 without it.
